ascii_load_sequencer: RTL and testbench
=======================================

// Module: ascii_load_sequencer
// PURPOSE
//  Sequences the two text-load sources (OSD file download, UART bytes) into the ACIA receive register.
//  Buffers ioctl bytes and back-pressures hps_io via ioctl_wait.
//  Paces delivery so the monitor/BASIC can keep up, and normalises line endings to CR.
//  Sits between hps_io/UART deserialiser and the ACIA inside uk101.
// PARAMETERS
//  FIFO_DEPTH  16      ioctl byte buffer depth, power of two, >=4
//  CHAR_GAP    2000    clk cycles idle after each byte is read by the CPU
//  CR_GAP      200000  clk cycles idle after a CR is read (BASIC line entry)
// PORTS
//  clk             in   1  system clock (48 MHz)
//  n_reset         in   1  asynchronous active-low reset
//  load_from       in   1  0=file (ioctl), 1=UART; sampled only in S_IDLE
//  ioctl_download  in   1  file transfer active
//  ioctl_wr        in   1  ioctl_data valid this cycle
//  ioctl_data      in   8  downloaded byte
//  ioctl_wait      out  1  stall hps_io; FIFO near full
//  uart_valid      in   1  1-cycle pulse, uart_byte valid
//  uart_byte       in   8  deserialised UART byte
//  rx_data         out  8  byte presented to ACIA receive register
//  rx_full         out  1  ACIA RDRF: rx_data valid, awaiting CPU read
//  rx_ack          in   1  1-cycle pulse: CPU read ACIA data register
//  busy            out  1  file load in progress (FIFO non-empty or download high)
//  done            out  1  1-cycle pulse: file fully delivered
// BEHAVIOUR
//  Reset (async, n_reset=0): all outputs 0, FIFO empty, state S_IDLE, counters 0, last_cr=0.
//  FIFO write: ioctl_wr && ioctl_download && load_from==0; ioctl_wait registered, =1 when count>=FIFO_DEPTH-2.
//   Writes while full are dropped and set sticky overflow flag (debug only; cleared on reset).
//  Line endings: LF immediately following CR is discarded; bare LF is replaced by CR; other bytes pass unchanged.
//  FSM (registered, one transition per cycle):
//   S_IDLE:    src=load_from latched. file: FIFO non-empty -> S_FETCH.
//              UART: uart_valid -> load rx_data, rx_full=1 -> S_PRESENT.
//   S_FETCH:   pop FIFO (1-cycle read latency). Discarded LF -> S_IDLE. Otherwise rx_data<=byte, rx_full<=1 -> S_PRESENT.
//   S_PRESENT: hold rx_full until rx_ack. Then rx_full<=0, gap<=(byte==CR)?CR_GAP:CHAR_GAP -> S_GAP.
//   S_GAP:     decrement gap each cycle; at 0 -> S_IDLE. UART bytes arriving here are dropped (UART has no buffer).
//  UART src in S_PRESENT: a second uart_valid overwrites rx_data (ACIA overrun semantics), rx_full stays 1.
//  rx_ack outside S_PRESENT is ignored. rx_ack and uart_valid in the same cycle: ack completes first, new byte dropped.
//  done: pulses 1 cycle on ioctl_download falling edge seen earlier, once FIFO empty and FSM returns to S_IDLE.
//  load_from change mid-transfer: takes effect only in S_IDLE with FIFO empty; file bytes are never reordered or lost.
//  Latency: FIFO write to rx_full >= 3 cycles when idle. Simultaneous push/pop keeps count unchanged.
//  Pointers are log2(FIFO_DEPTH)+1 bits; they wrap naturally; full = MSB differ && rest equal.
// STRUCTURE
//  Package uk101_load_pkg: state enum {S_IDLE,S_FETCH,S_PRESENT,S_GAP}; ASCII_CR=8'h0D; ASCII_LF=8'h0A; gap counter width 18.
//  Sub-module load_fifo (sync FIFO, registered read, count output) instantiated once; FSM, LF filter and pacing live in top.
// TESTING
//  1 File "AB\r\n" via ioctl, ack each byte immediately -> rx_data 41,42,0D only. Gaps 2000/2000/200000 cycles. done pulses once.
//  2 Burst 20 ioctl writes, no rx_ack -> ioctl_wait=1 at count 14. With hps_io honouring wait, no overflow and all 20 bytes delivered in order.
//  3 load_from=1, uart_valid with 0x31, then 0x32 before ack -> rx_data=32, rx_full=1; after ack, gap 2000, then idle.
//  4 Bare LF (0x0A not after CR) in file -> delivered as 0D with CR_GAP. "\r\r\n" -> 0D,0D.
//  5 n_reset low in S_PRESENT mid-file -> rx_full, ioctl_wait, busy, done all 0 immediately. FIFO empty. No spurious done after release.
//  6 Toggle load_from 0->1 while file FIFO holds 5 bytes -> all 5 file bytes delivered before any UART byte is accepted.

Source files
------------

// File: rtl/uk101_load_pkg.sv
// -----------------------------------------------------------------------------
// uk101_load_pkg
// Shared types and constants for the UK101 text-load path (ascii_load_sequencer
// and its FIFO). Holds the sequencer state encoding, the load-source encoding,
// the ASCII line-ending codes and the pacing counter type.
// -----------------------------------------------------------------------------
package uk101_load_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_FETCH,
    S_PRESENT,
    S_GAP
  } state_t;

  typedef enum logic {
    SRC_FILE = 1'b0,
    SRC_UART = 1'b1
  } src_t;

  localparam logic [7:0] ASCII_CR = 8'h0D;
  localparam logic [7:0] ASCII_LF = 8'h0A;

  // 18 bits covers the 200000-cycle line-entry pause at 48 MHz.
  localparam int GAP_W = 18;
  typedef logic [GAP_W-1:0] gap_t;

endpackage

// File: rtl/ascii_load_sequencer_if.sv
// -----------------------------------------------------------------------------
// ascii_load_sequencer_if
// Bundles the text-load signals between hps_io / UART deserialiser / ACIA and
// the ascii_load_sequencer.
//   load_from       source select: 0 = file (ioctl), 1 = UART
//   ioctl_*         file download stream; ioctl_wait stalls hps_io
//   uart_valid/byte one-cycle UART byte strobe
//   rx_data/rx_full byte presented to the ACIA receive register (RDRF)
//   rx_ack          one-cycle pulse: CPU read the ACIA data register
//   busy / done     file load status and end-of-file pulse
// Modports: master = surrounding system, slave = sequencer.
// -----------------------------------------------------------------------------
interface ascii_load_sequencer_if;

  logic       load_from;
  logic       ioctl_download;
  logic       ioctl_wr;
  logic [7:0] ioctl_data;
  logic       ioctl_wait;
  logic       uart_valid;
  logic [7:0] uart_byte;
  logic [7:0] rx_data;
  logic       rx_full;
  logic       rx_ack;
  logic       busy;
  logic       done;

  modport master (
    output load_from, ioctl_download, ioctl_wr, ioctl_data,
           uart_valid, uart_byte, rx_ack,
    input  ioctl_wait, rx_data, rx_full, busy, done
  );

  modport slave (
    input  load_from, ioctl_download, ioctl_wr, ioctl_data,
           uart_valid, uart_byte, rx_ack,
    output ioctl_wait, rx_data, rx_full, busy, done
  );

endinterface

// File: rtl/load_fifo.sv
// -----------------------------------------------------------------------------
// load_fifo
// Synchronous FIFO buffering downloaded file bytes.
//   clk, n_reset     clock, asynchronous active-low reset
//   wr_en, wr_data   push (ignored while full; sets a sticky overflow flag)
//   rd_en, rd_data   pop; rd_data is registered and valid the cycle after pop
//   empty, count     occupancy status (combinational from the pointers)
//   almost_full      registered, high while occupancy >= DEPTH-2
// Pointers carry one extra wrap bit: full when the wrap bits differ and the
// index bits match. The sticky overflow flag is for debug inspection only.
// -----------------------------------------------------------------------------
module load_fifo #(
  parameter  int DEPTH = 16,
  parameter  int WIDTH = 8,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             n_reset,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             empty,
  output logic [AW:0]      count,
  output logic             almost_full
);

  typedef logic [AW:0] ptr_t;

  ptr_t             wr_ptr;
  ptr_t             rd_ptr;
  ptr_t             count_next;
  logic             full;
  logic             push;
  logic             pop;
  logic             overflow;
  logic [WIDTH-1:0] mem [DEPTH];

  assign empty      = (wr_ptr == rd_ptr);
  assign full       = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign count      = wr_ptr - rd_ptr;
  assign push       = wr_en && !full;
  assign pop        = rd_en && !empty;
  // Simultaneous push and pop leave the occupancy unchanged.
  assign count_next = count + ptr_t'(push) - ptr_t'(pop);

  // NOTE: the storage array is deliberately left out of reset; only the
  // pointers define which entries are valid, and a resettable array would
  // prevent mapping onto RAM.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= wr_data;
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      rd_data     <= '0;
      almost_full <= 1'b0;
      overflow    <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + ptr_t'(1);
      if (pop) begin
        rd_ptr  <= rd_ptr + ptr_t'(1);
        rd_data <= mem[rd_ptr[AW-1:0]];
      end
      // Evaluated on the next occupancy so the stall is visible in the same
      // cycle the threshold is reached.
      almost_full <= (count_next >= ptr_t'(DEPTH - 2));
      overflow    <= overflow | (wr_en && full);
    end
  end

endmodule

// File: rtl/ascii_load_sequencer.sv
// -----------------------------------------------------------------------------
// ascii_load_sequencer
// Feeds text into the UK101 ACIA receive register from either the OSD file
// download (buffered in load_fifo, back-pressured with ioctl_wait) or the UART
// deserialiser. Bytes are paced: after the CPU reads a byte the sequencer
// idles CHAR_GAP cycles, or CR_GAP cycles after a CR so BASIC can process the
// line. File line endings are normalised to CR (CR LF -> CR, bare LF -> CR).
//   clk, n_reset  clock, asynchronous active-low reset
//   bus (slave)   see ascii_load_sequencer_if
// Parameters: FIFO_DEPTH (power of two, >= 4), CHAR_GAP, CR_GAP (< 2**18).
// -----------------------------------------------------------------------------
module ascii_load_sequencer
  import uk101_load_pkg::*;
#(
  parameter int FIFO_DEPTH = 16,
  parameter int CHAR_GAP   = 2000,
  parameter int CR_GAP     = 200000
) (
  input  logic                  clk,
  input  logic                  n_reset,
  ascii_load_sequencer_if.slave bus
);

  localparam int AW = $clog2(FIFO_DEPTH);

  state_t      state;
  src_t        src;
  gap_t        gap;
  logic [7:0]  rx_data_q;
  logic        rx_full_q;
  logic        busy_q;
  logic        done_q;
  logic        done_pending;
  logic        download_q;
  logic        last_cr;

  logic        fifo_wr;
  logic        fifo_rd;
  logic [7:0]  fifo_rd_data;
  logic        fifo_empty;
  logic [AW:0] fifo_count;
  logic        fifo_almost_full;

  // File bytes are only accepted while the file source is selected.
  assign fifo_wr = bus.ioctl_wr && bus.ioctl_download && !bus.load_from;
  // The pop is issued on the IDLE->FETCH transition; the registered FIFO read
  // data is then consumed in S_FETCH.
  assign fifo_rd = (state == S_IDLE) && !fifo_empty;

  load_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (8)
  ) u_fifo (
    .clk         (clk),
    .n_reset     (n_reset),
    .wr_en       (fifo_wr),
    .wr_data     (bus.ioctl_data),
    .rd_en       (fifo_rd),
    .rd_data     (fifo_rd_data),
    .empty       (fifo_empty),
    .count       (fifo_count),
    .almost_full (fifo_almost_full)
  );

  assign bus.ioctl_wait = fifo_almost_full;
  assign bus.rx_data    = rx_data_q;
  assign bus.rx_full    = rx_full_q;
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      state        <= S_IDLE;
      src          <= SRC_FILE;
      gap          <= '0;
      rx_data_q    <= '0;
      rx_full_q    <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      done_pending <= 1'b0;
      download_q   <= 1'b0;
      last_cr      <= 1'b0;
    end else begin
      download_q <= bus.ioctl_download;
      busy_q     <= bus.ioctl_download || (fifo_count != '0);
      done_q     <= 1'b0;
      // Remember the end of a download until every buffered byte is delivered.
      if (download_q && !bus.ioctl_download) done_pending <= 1'b1;

      case (state)
        S_IDLE: begin
          if (!fifo_empty) begin
            // Buffered file bytes always drain before the source may change.
            src   <= SRC_FILE;
            state <= S_FETCH;
          end else begin
            src <= src_t'(bus.load_from);
            if (bus.load_from && bus.uart_valid) begin
              rx_data_q <= bus.uart_byte;
              rx_full_q <= 1'b1;
              state     <= S_PRESENT;
            end else if (done_pending && !bus.ioctl_download) begin
              done_q       <= 1'b1;
              done_pending <= 1'b0;
            end
          end
        end

        S_FETCH: begin
          if (fifo_rd_data == ASCII_LF && last_cr) begin
            // Second half of a CR LF pair: drop it, nothing reaches the ACIA.
            last_cr <= 1'b0;
            state   <= S_IDLE;
          end else begin
            rx_data_q <= (fifo_rd_data == ASCII_LF) ? ASCII_CR : fifo_rd_data;
            last_cr   <= (fifo_rd_data == ASCII_CR);
            rx_full_q <= 1'b1;
            state     <= S_PRESENT;
          end
        end

        S_PRESENT: begin
          if (bus.rx_ack) begin
            // The ack wins over a UART byte arriving in the same cycle.
            rx_full_q <= 1'b0;
            gap       <= (rx_data_q == ASCII_CR) ? gap_t'(CR_GAP) : gap_t'(CHAR_GAP);
            state     <= S_GAP;
          end else if (src == SRC_UART && bus.uart_valid) begin
            // ACIA overrun: the newer UART byte replaces the unread one.
            rx_data_q <= bus.uart_byte;
          end
        end

        S_GAP: begin
          // UART bytes arriving here are lost; the UART path has no buffer.
          if (gap == '0) state <= S_IDLE;
          else           gap   <= gap - gap_t'(1);
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ascii_load_sequencer.sv
// -----------------------------------------------------------------------------
// tb_ascii_load_sequencer
// Directed bench for ascii_load_sequencer with shortened pacing gaps.
// -----------------------------------------------------------------------------
module tb_ascii_load_sequencer;
  import uk101_load_pkg::*;

  localparam int CHAR_GAP = 20;
  localparam int CR_GAP   = 60;
  localparam int BUDGET   = 1000;

  logic clk     = 1'b0;
  logic n_reset = 1'b0;

  int tests_run    = 0;
  int tests_failed = 0;
  int done_cnt     = 0;

  ascii_load_sequencer_if bus ();

  ascii_load_sequencer #(
    .FIFO_DEPTH (16),
    .CHAR_GAP   (CHAR_GAP),
    .CR_GAP     (CR_GAP)
  ) u_dut (
    .clk     (clk),
    .n_reset (n_reset),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (bus.done === 1'b1) done_cnt++;

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
    $fatal(1, "watchdog");
  end

  // ---------------------------------------------------------------- helpers
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr_byte(input logic [7:0] b);
    bus.ioctl_wr   = 1'b1;
    bus.ioctl_data = b;
    tick();
    bus.ioctl_wr   = 1'b0;
  endtask

  task automatic uart_pulse(input logic [7:0] b);
    bus.uart_valid = 1'b1;
    bus.uart_byte  = b;
    tick();
    bus.uart_valid = 1'b0;
  endtask

  // Waits for rx_full, captures the byte and acknowledges it for one cycle.
  // cyc is the number of clock edges waited for rx_full.
  task automatic recv(output logic [7:0] b, output int cyc, output bit ok);
    cyc = 0;
    while (bus.rx_full !== 1'b1 && cyc < BUDGET) begin
      tick();
      cyc++;
    end
    ok = (bus.rx_full === 1'b1);
    b  = bus.rx_data;
    if (ok) begin
      bus.rx_ack = 1'b1;
      tick();
      bus.rx_ack = 1'b0;
    end
  endtask

  task automatic wait_done(output int cyc);
    cyc = 0;
    while (bus.done !== 1'b1 && cyc < BUDGET) begin
      tick();
      cyc++;
    end
  endtask

  // ---------------------------------------------------------------- tests
  task automatic test_reset();
    logic [11:0] obs;
    repeat (3) tick();
    obs = {bus.rx_full, bus.ioctl_wait, bus.busy, bus.done, bus.rx_data};
    tests_run++;
    if (obs !== 12'h000) begin
      tests_failed++;
      $display("FAIL reset_held: got %h, required 000", obs);
    end
    n_reset = 1'b1;
    repeat (3) tick();
    obs = {bus.rx_full, bus.ioctl_wait, bus.busy, bus.done, bus.rx_data};
    tests_run++;
    if (obs !== 12'h000) begin
      tests_failed++;
      $display("FAIL reset_released: got %h, required 000", obs);
    end
  endtask

  task automatic test_file_ab();
    logic [7:0] exp [3] = '{8'h41, 8'h42, ASCII_CR};
    logic [7:0] b;
    int         cyc;
    bit         ok;
    int         base;
    base = done_cnt;
    bus.load_from      = 1'b0;
    bus.ioctl_download = 1'b1;
    wr_byte(8'h41);
    wr_byte(8'h42);
    wr_byte(ASCII_CR);
    wr_byte(ASCII_LF);
    bus.ioctl_download = 1'b0;
    for (int i = 0; i < 3; i++) begin
      recv(b, cyc, ok);
      tests_run++;
      if (!ok || b !== exp[i]) begin
        tests_failed++;
        $display("FAIL file_ab_byte%0d: got %h (ok=%0d), required %h", i, b, ok, exp[i]);
      end
      if (i > 0) begin
        tests_run++;
        if (cyc < CHAR_GAP || cyc > CHAR_GAP + 8) begin
          tests_failed++;
          $display("FAIL file_ab_gap%0d: got %0d cycles, required %0d..%0d",
                   i, cyc, CHAR_GAP, CHAR_GAP + 8);
        end
      end
    end
    wait_done(cyc);
    tests_run++;
    if (cyc < CR_GAP || cyc > CR_GAP + 10) begin
      tests_failed++;
      $display("FAIL file_ab_cr_gap: got %0d cycles to done, required %0d..%0d",
               cyc, CR_GAP, CR_GAP + 10);
    end
    repeat (20) tick();
    tests_run++;
    if (done_cnt - base !== 1) begin
      tests_failed++;
      $display("FAIL file_ab_done_once: got %0d pulses, required 1", done_cnt - base);
    end
    tests_run++;
    if ({bus.rx_full, bus.busy} !== 2'b00) begin
      tests_failed++;
      $display("FAIL file_ab_idle: got rx_full,busy=%b, required 00", {bus.rx_full, bus.busy});
    end
  endtask

  task automatic test_burst();
    logic [7:0] got [20];
    bit         got_ok [20];
    int         cyc;
    bus.load_from      = 1'b0;
    bus.ioctl_download = 1'b1;
    for (int i = 0; i < 15; i++) begin
      wr_byte(8'h40 + 8'(i));
      if (i == 13) begin
        tests_run++;
        if (bus.ioctl_wait !== 1'b0) begin
          tests_failed++;
          $display("FAIL burst_wait_13: got %b at count 13, required 0", bus.ioctl_wait);
        end
      end
    end
    tests_run++;
    if (bus.ioctl_wait !== 1'b1) begin
      tests_failed++;
      $display("FAIL burst_wait_14: got %b at count 14, required 1", bus.ioctl_wait);
    end
    tests_run++;
    if (bus.rx_full !== 1'b1 || bus.rx_data !== 8'h40) begin
      tests_failed++;
      $display("FAIL burst_hold: got rx_full=%b rx_data=%h, required 1/40", bus.rx_full, bus.rx_data);
    end
    fork
      begin
        for (int i = 15; i < 20; i++) begin
          cyc = 0;
          while (bus.ioctl_wait === 1'b1 && cyc < BUDGET) begin
            tick();
            cyc++;
          end
          wr_byte(8'h40 + 8'(i));
        end
        bus.ioctl_download = 1'b0;
      end
      begin
        int c;
        for (int i = 0; i < 20; i++) recv(got[i], c, got_ok[i]);
      end
    join
    for (int i = 0; i < 20; i++) begin
      tests_run++;
      if (!got_ok[i] || got[i] !== 8'h40 + 8'(i)) begin
        tests_failed++;
        $display("FAIL burst_byte%0d: got %h (ok=%0d), required %h", i, got[i], got_ok[i], 8'h40 + 8'(i));
      end
    end
    wait_done(cyc);
    tests_run++;
    if (bus.done !== 1'b1) begin
      tests_failed++;
      $display("FAIL burst_done: got no done pulse, required one");
    end
    repeat (5) tick();
  endtask

  task automatic test_uart();
    logic [7:0] b;
    int         cyc;
    bit         ok;
    bus.load_from = 1'b1;
    tick();
    uart_pulse(8'h31);
    tests_run++;
    if (bus.rx_full !== 1'b1 || bus.rx_data !== 8'h31) begin
      tests_failed++;
      $display("FAIL uart_first: got rx_full=%b rx_data=%h, required 1/31", bus.rx_full, bus.rx_data);
    end
    uart_pulse(8'h32);
    tests_run++;
    if (bus.rx_full !== 1'b1 || bus.rx_data !== 8'h32) begin
      tests_failed++;
      $display("FAIL uart_overrun: got rx_full=%b rx_data=%h, required 1/32", bus.rx_full, bus.rx_data);
    end
    // Ack and a new byte in the same cycle: ack completes, byte dropped.
    bus.rx_ack     = 1'b1;
    bus.uart_valid = 1'b1;
    bus.uart_byte  = 8'h33;
    tick();
    bus.rx_ack     = 1'b0;
    bus.uart_valid = 1'b0;
    tests_run++;
    if (bus.rx_full !== 1'b0) begin
      tests_failed++;
      $display("FAIL uart_ack_wins: got rx_full=%b, required 0", bus.rx_full);
    end
    // A byte during the gap is lost.
    uart_pulse(8'h34);
    tests_run++;
    if (bus.rx_full !== 1'b0) begin
      tests_failed++;
      $display("FAIL uart_gap_drop: got rx_full=%b rx_data=%h, required rx_full 0", bus.rx_full, bus.rx_data);
    end
    // Offer a byte every cycle until it is taken; that marks the end of the gap.
    cyc = 1;
    while (bus.rx_full !== 1'b1 && cyc < CHAR_GAP + 30) begin
      bus.uart_valid = 1'b1;
      bus.uart_byte  = 8'h36;
      tick();
      cyc++;
    end
    bus.uart_valid = 1'b0;
    tests_run++;
    if (bus.rx_data !== 8'h36 || cyc < CHAR_GAP || cyc > CHAR_GAP + 6) begin
      tests_failed++;
      $display("FAIL uart_gap_len: got rx_data=%h after %0d cycles, required 36 after %0d..%0d",
               bus.rx_data, cyc, CHAR_GAP, CHAR_GAP + 6);
    end
    recv(b, cyc, ok);
    repeat (CHAR_GAP + 10) tick();
    bus.load_from = 1'b0;
    tick();
  endtask

  task automatic test_line_endings();
    logic [7:0] exp [5] = '{8'h58, ASCII_CR, 8'h59, ASCII_CR, ASCII_CR};
    logic [7:0] b;
    int         cyc;
    bit         ok;
    int         gap_exp;
    bus.load_from      = 1'b0;
    bus.ioctl_download = 1'b1;
    wr_byte(8'h58);
    wr_byte(ASCII_LF);
    wr_byte(8'h59);
    wr_byte(ASCII_CR);
    wr_byte(ASCII_CR);
    wr_byte(ASCII_LF);
    bus.ioctl_download = 1'b0;
    for (int i = 0; i < 5; i++) begin
      recv(b, cyc, ok);
      tests_run++;
      if (!ok || b !== exp[i]) begin
        tests_failed++;
        $display("FAIL eol_byte%0d: got %h (ok=%0d), required %h", i, b, ok, exp[i]);
      end
      if (i > 0) begin
        gap_exp = (exp[i-1] == ASCII_CR) ? CR_GAP : CHAR_GAP;
        tests_run++;
        if (cyc < gap_exp || cyc > gap_exp + 8) begin
          tests_failed++;
          $display("FAIL eol_gap%0d: got %0d cycles, required %0d..%0d", i, cyc, gap_exp, gap_exp + 8);
        end
      end
    end
    wait_done(cyc);
    tests_run++;
    if (cyc < CR_GAP || cyc > CR_GAP + 10) begin
      tests_failed++;
      $display("FAIL eol_done: got %0d cycles to done, required %0d..%0d", cyc, CR_GAP, CR_GAP + 10);
    end
    repeat (5) tick();
  endtask

  task automatic test_reset_mid();
    logic [11:0] obs;
    int          base;
    bus.load_from      = 1'b0;
    bus.ioctl_download = 1'b1;
    for (int i = 0; i < 15; i++) wr_byte(8'h60 + 8'(i));
    tick();
    tests_run++;
    if ({bus.rx_full, bus.ioctl_wait, bus.busy} !== 3'b111) begin
      tests_failed++;
      $display("FAIL rst_mid_pre: got rx_full,wait,busy=%b, required 111",
               {bus.rx_full, bus.ioctl_wait, bus.busy});
    end
    #2;
    n_reset            = 1'b0;
    bus.ioctl_download = 1'b0;
    #1;
    obs = {bus.rx_full, bus.ioctl_wait, bus.busy, bus.done, bus.rx_data};
    tests_run++;
    if (obs !== 12'h000) begin
      tests_failed++;
      $display("FAIL rst_mid_async: got %h, required 000", obs);
    end
    tick();
    tick();
    base    = done_cnt;
    n_reset = 1'b1;
    repeat (40) tick();
    obs = {bus.rx_full, bus.ioctl_wait, bus.busy, bus.done, bus.rx_data};
    tests_run++;
    if (obs !== 12'h000 || done_cnt != base) begin
      tests_failed++;
      $display("FAIL rst_mid_after: got %h with %0d done pulses, required 000 with 0",
               obs, done_cnt - base);
    end
  endtask

  task automatic test_src_switch();
    logic [7:0] b;
    int         cyc;
    bit         ok;
    bus.load_from      = 1'b0;
    bus.ioctl_download = 1'b1;
    for (int i = 0; i < 5; i++) wr_byte(8'h61 + 8'(i));
    bus.ioctl_download = 1'b0;
    bus.load_from      = 1'b1;
    for (int i = 0; i < 5; i++) begin
      uart_pulse(8'h55);
      recv(b, cyc, ok);
      tests_run++;
      if (!ok || b !== 8'h61 + 8'(i)) begin
        tests_failed++;
        $display("FAIL src_file_byte%0d: got %h (ok=%0d), required %h", i, b, ok, 8'h61 + 8'(i));
      end
    end
    repeat (CHAR_GAP + 10) tick();
    uart_pulse(8'h77);
    tests_run++;
    if (bus.rx_full !== 1'b1 || bus.rx_data !== 8'h77) begin
      tests_failed++;
      $display("FAIL src_uart_after: got rx_full=%b rx_data=%h, required 1/77", bus.rx_full, bus.rx_data);
    end
    recv(b, cyc, ok);
    bus.load_from = 1'b0;
    repeat (CHAR_GAP + 10) tick();
  endtask

  initial begin
    bus.load_from      = 1'b0;
    bus.ioctl_download = 1'b0;
    bus.ioctl_wr       = 1'b0;
    bus.ioctl_data     = 8'h00;
    bus.uart_valid     = 1'b0;
    bus.uart_byte      = 8'h00;
    bus.rx_ack         = 1'b0;
    test_reset();
    test_file_ab();
    test_burst();
    test_uart();
    test_line_endings();
    test_reset_mid();
    test_src_switch();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
